// File: rtl/gpio_conv_sequencer_if.sv
// gpio_conv_sequencer_if: GPIO command/status words plus datapath control strobes of the sequencer.
interface gpio_conv_sequencer_if #(
  parameter int GPIO_D      = 32,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_DATA   = 13,
  parameter int NB_ADDRESS  = 4
);
  logic [GPIO_D-1:0]      i_gpio;
  logic [GPIO_D-1:0]      o_gpio;
  logic                   i_eop;
  logic [BITS_DATA-1:0]   i_data;
  logic [BITS_IMAGEN-1:0] o_data;
  logic                   o_ki;
  logic                   o_load;
  logic                   o_sop;
  logic                   o_valid;
  logic [NB_ADDRESS-1:0]  o_imglen;
  logic                   o_soft_rst;
  modport master (
    input  i_gpio, i_eop, i_data,
    output o_gpio, o_data, o_ki, o_load, o_sop, o_valid, o_imglen, o_soft_rst
  );
  modport slave (
    output i_gpio, i_eop, i_data,
    input  o_gpio, o_data, o_ki, o_load, o_sop, o_valid, o_imglen, o_soft_rst
  );
endinterface

// File: rtl/gpio_conv_sequencer.sv
// gpio_conv_sequencer: decodes toggle-strobed GPIO opcodes into convolution datapath strobes.
// Define CTRL_TIMEOUT_EN to add a 16-bit run watchdog that aborts a stalled run.
module gpio_conv_sequencer #(
  parameter int GPIO_D      = 32,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_DATA   = 13,
  parameter int NB_ADDRESS  = 4,
  parameter int M_LEN       = 3,
  parameter int READ_LAT    = 2
) (
  input logic i_CLK,
  input logic i_reset,
  gpio_conv_sequencer_if.master bus
);
  localparam int KN = M_LEN * M_LEN;
  localparam int KW = $clog2(KN + 1);
  localparam int RW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [KW-1:0] K_FULL = KW'(KN);
  localparam logic [RW-1:0] RD_LAST = RW'(READ_LAT - 1);
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_RUN, S_READ, S_ACK} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_SOFT_RST, OP_LOAD_KERNEL, OP_LOAD_IMGLEN,
    OP_LOAD_IMAGE, OP_START, OP_READ_NEXT, OP_STATUS
  } op_t;
  state_t                 state;
  op_t                    op;
  logic [BITS_IMAGEN-1:0] payload;
  logic                   strobe_q;
  logic                   ack;
  logic                   err;
  logic                   done;
  logic [KW-1:0]          k_cnt;
  logic [RW-1:0]          rd_cnt;
  logic [BITS_DATA-1:0]   rd_data;
`ifdef CTRL_TIMEOUT_EN
  logic [15:0]            wd;
`endif
  assign bus.o_gpio = {state != S_IDLE, done, ack, err, 3'(state),
                       {(GPIO_D - 7 - BITS_DATA){1'b0}}, rd_data};
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      state          <= S_IDLE;
      op             <= OP_NOP;
      payload        <= '0;
      strobe_q       <= 1'b0;
      ack            <= 1'b0;
      err            <= 1'b0;
      done           <= 1'b0;
      k_cnt          <= '0;
      rd_cnt         <= '0;
      rd_data        <= '0;
      bus.o_data     <= '0;
      bus.o_ki       <= 1'b1;
      bus.o_load     <= 1'b0;
      bus.o_sop      <= 1'b0;
      bus.o_valid    <= 1'b0;
      bus.o_imglen   <= '1;
      bus.o_soft_rst <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
      wd             <= '0;
`endif
    end else begin
      bus.o_load     <= 1'b0;
      bus.o_sop      <= 1'b0;
      bus.o_valid    <= 1'b0;
      bus.o_soft_rst <= 1'b0;
      // o_ki trails the final kernel word by one cycle; a soft reset below overrides it
      if (k_cnt == K_FULL) bus.o_ki <= 1'b0;
      case (state)
        S_IDLE: if (bus.i_gpio[28] != strobe_q) begin
          op       <= op_t'(bus.i_gpio[31:29]);
          payload  <= bus.i_gpio[BITS_IMAGEN-1:0];
          strobe_q <= bus.i_gpio[28];
          state    <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_ACK;
          case (op)
            OP_SOFT_RST: begin
              bus.o_soft_rst <= 1'b1;
              k_cnt          <= '0;
              err            <= 1'b0;
              done           <= 1'b0;
              bus.o_imglen   <= '1;
              bus.o_ki       <= 1'b1;
            end
            OP_LOAD_KERNEL: if (k_cnt < K_FULL) begin
              bus.o_data <= payload;
              bus.o_load <= 1'b1;
              k_cnt      <= k_cnt + 1'b1;
            end else err <= 1'b1;
            OP_LOAD_IMGLEN: if (payload[NB_ADDRESS-1:0] == '0) err <= 1'b1;
                            else bus.o_imglen <= payload[NB_ADDRESS-1:0];
            OP_LOAD_IMAGE: if (!bus.o_ki) begin
              bus.o_data <= payload;
              bus.o_load <= 1'b1;
            end else err <= 1'b1;
            OP_START: if (k_cnt == K_FULL) begin
              bus.o_sop <= 1'b1;
              done      <= 1'b0;
              state     <= S_RUN;
`ifdef CTRL_TIMEOUT_EN
              wd        <= '0;
`endif
            end else err <= 1'b1;
            OP_READ_NEXT: if (done) begin
              bus.o_valid <= 1'b1;
              rd_cnt      <= '0;
              state       <= S_READ;
            end else err <= 1'b1;
            default: ;
          endcase
        end
        S_RUN: begin
`ifdef CTRL_TIMEOUT_EN
          if (bus.i_eop) begin
            done  <= 1'b1;
            state <= S_ACK;
          end else if (wd == 16'hFFFF) begin
            err            <= 1'b1;
            bus.o_soft_rst <= 1'b1;
            state          <= S_ACK;
          end else wd <= wd + 16'd1;
`else
          if (bus.i_eop) begin
            done  <= 1'b1;
            state <= S_ACK;
          end
`endif
        end
        S_READ: if (rd_cnt == RD_LAST) begin
          rd_data <= bus.i_data;
          state   <= S_ACK;
        end else rd_cnt <= rd_cnt + 1'b1;
        S_ACK: begin
          ack   <= strobe_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_conv_sequencer.sv
// tb_gpio_conv_sequencer: scoreboard bench for the GPIO command sequencer.
module tb_gpio_conv_sequencer;
  localparam logic [2:0] NOP = 3'd0, SRST = 3'd1, LKER = 3'd2, LLEN = 3'd3,
                         LIMG = 3'd4, STRT = 3'd5, RDNX = 3'd6;
  logic i_CLK = 1'b0;
  logic i_reset = 1'b1;
  gpio_conv_sequencer_if bus ();
  gpio_conv_sequencer dut (.i_CLK(i_CLK), .i_reset(i_reset), .bus(bus));
  always #5 i_CLK = ~i_CLK;

  int vectors = 0;
  int miscompares = 0;
  int n_load = 0, n_sop = 0, n_valid = 0, n_srst = 0, wide = 0;
  logic p_load = 0, p_sop = 0, p_valid = 0, p_srst = 0;
  logic strb = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [12:0] rd_exp[$];

  task automatic tick();
    @(negedge i_CLK);
    if (bus.o_load) got_q.push_back(bus.o_data);
    if (bus.o_load) n_load++;
    if (bus.o_sop) n_sop++;
    if (bus.o_valid) n_valid++;
    if (bus.o_soft_rst) n_srst++;
    if ((bus.o_load && p_load) || (bus.o_sop && p_sop) || (bus.o_valid && p_valid) || (bus.o_soft_rst && p_srst)) wide++;
    p_load = bus.o_load; p_sop = bus.o_sop; p_valid = bus.o_valid; p_srst = bus.o_soft_rst;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] pl);
    strb = ~strb;
    bus.i_gpio = {op, strb, 20'd0, pl};
  endtask

  task automatic wait_ack(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.o_gpio[29] == strb) begin n = i; break; end
    end
  endtask

  task automatic issue_wait(input logic [2:0] op, input logic [7:0] pl, output int n);
    issue(op, pl);
    wait_ack(n);
  endtask

  task automatic test_reset();
    bus.i_gpio = '0; bus.i_eop = 1'b0; bus.i_data = '0;
    repeat (2) tick();
    i_reset = 1'b0;
    tick();
    vectors++; if (bus.o_imglen !== 4'hF) begin miscompares++; $display("FAIL reset_imglen got %h want f", bus.o_imglen); end
    vectors++; if (bus.o_ki !== 1'b1) begin miscompares++; $display("FAIL reset_ki got %b want 1", bus.o_ki); end
    vectors++; if (bus.o_gpio !== 32'h0) begin miscompares++; $display("FAIL reset_gpio got %h want 0", bus.o_gpio); end
    vectors++; if ({bus.o_load, bus.o_sop, bus.o_valid, bus.o_soft_rst, bus.o_data} !== 12'h0) begin
      miscompares++; $display("FAIL reset_pulses got %b/%h want 0", {bus.o_load, bus.o_sop, bus.o_valid, bus.o_soft_rst}, bus.o_data); end
  endtask

  task automatic test_start_early();
    int n;
    logic [7:0] e, g;
    issue_wait(RDNX, 8'h0, n);
    vectors++; if (n_valid !== 0) begin miscompares++; $display("FAIL read_not_done_valid got %0d want 0", n_valid); end
    vectors++; if (bus.o_gpio[28] !== 1'b1) begin miscompares++; $display("FAIL read_not_done_err got %b want 1", bus.o_gpio[28]); end
    issue_wait(SRST, 8'h0, n);
    vectors++; if (n_srst !== 1) begin miscompares++; $display("FAIL softrst_pulse got %0d want 1", n_srst); end
    vectors++; if (bus.o_gpio[28] !== 1'b0) begin miscompares++; $display("FAIL softrst_err got %b want 0", bus.o_gpio[28]); end
    issue_wait(LIMG, 8'h33, n);
    vectors++; if ({n_load, bus.o_gpio[28]} !== {32'd0, 1'b1}) begin miscompares++; $display("FAIL image_before_kernel got load=%0d err=%b want 0/1", n_load, bus.o_gpio[28]); end
    issue_wait(SRST, 8'h0, n);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i));
      issue_wait(LKER, 8'(i), n);
    end
    issue_wait(STRT, 8'h0, n);
    vectors++; if (n_sop !== 0) begin miscompares++; $display("FAIL early_start_sop got %0d want 0", n_sop); end
    vectors++; if (bus.o_gpio[28] !== 1'b1) begin miscompares++; $display("FAIL early_start_err got %b want 1", bus.o_gpio[28]); end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL early_start_ack_latency got %0d want 3", n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      vectors++; if (g !== e) begin miscompares++; $display("FAIL early_kernel_data got %h want %h", g, e); end
    end
    issue_wait(SRST, 8'h0, n);
  endtask

  task automatic test_imglen();
    int n;
    issue_wait(LLEN, 8'h0, n);
    vectors++; if ({bus.o_imglen, bus.o_gpio[28]} !== {4'hF, 1'b1}) begin miscompares++; $display("FAIL imglen_zero got %h err=%b want f/1", bus.o_imglen, bus.o_gpio[28]); end
    issue_wait(SRST, 8'h0, n);
    issue_wait(LLEN, 8'h5, n);
    vectors++; if ({bus.o_imglen, bus.o_gpio[28]} !== {4'h5, 1'b0}) begin miscompares++; $display("FAIL imglen_five got %h err=%b want 5/0", bus.o_imglen, bus.o_gpio[28]); end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL imglen_ack_latency got %0d want 3", n); end
  endtask

  task automatic test_kernel();
    int n, base;
    logic [7:0] e, g;
    base = n_load;
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back(8'(i));
      issue_wait(LKER, 8'(i), n);
      if (i == 8) begin
        vectors++; if (bus.o_ki !== 1'b1) begin miscompares++; $display("FAIL ki_after_8 got %b want 1", bus.o_ki); end
      end
    end
    vectors++; if (bus.o_ki !== 1'b0) begin miscompares++; $display("FAIL ki_after_9 got %b want 0", bus.o_ki); end
    vectors++; if (n_load - base !== 9) begin miscompares++; $display("FAIL kernel_loads got %0d want 9", n_load - base); end
    exp_q.push_back(8'hAA);
    issue_wait(LIMG, 8'hAA, n);
    vectors++; if (bus.o_gpio[28] !== 1'b0) begin miscompares++; $display("FAIL image_err got %b want 0", bus.o_gpio[28]); end
    issue_wait(LKER, 8'h0A, n);
    vectors++; if ({n_load - base, bus.o_gpio[28]} !== {32'd10, 1'b1}) begin miscompares++; $display("FAIL kernel_10th got loads=%0d err=%b want 10/1", n_load - base, bus.o_gpio[28]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      vectors++; if (g !== e) begin miscompares++; $display("FAIL kernel_data got %h want %h", g, e); end
    end
    vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL kernel_extra_loads got %0d want 0", got_q.size()); end
  endtask

  task automatic test_full_run();
    int n, base;
    issue_wait(LLEN, 8'h5, n);
    vectors++; if (bus.o_imglen !== 4'h5) begin miscompares++; $display("FAIL run_imglen got %h want 5", bus.o_imglen); end
    base = n_sop;
    issue(STRT, 8'h0);
    tick(); tick();
    vectors++; if (n_sop - base !== 1) begin miscompares++; $display("FAIL run_sop got %0d want 1", n_sop - base); end
    vectors++; if ({bus.o_gpio[31], bus.o_gpio[27:25]} !== 4'b1010) begin miscompares++; $display("FAIL run_busy got %b want 1010", {bus.o_gpio[31], bus.o_gpio[27:25]}); end
    repeat (17) tick();
    bus.i_eop = 1'b1;
    tick();
    bus.i_eop = 1'b0;
    wait_ack(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL run_ack_latency got %0d want 1", n); end
    vectors++; if ({bus.o_gpio[31], bus.o_gpio[30]} !== 2'b01) begin miscompares++; $display("FAIL run_done got busy/done=%b want 01", {bus.o_gpio[31], bus.o_gpio[30]}); end
    vectors++; if (n_sop - base !== 1) begin miscompares++; $display("FAIL run_sop_once got %0d want 1", n_sop - base); end
  endtask

  task automatic test_read();
    int n, base;
    logic [12:0] e;
    base = n_valid;
    bus.i_data = 13'h0ABC;
    rd_exp.push_back(13'h0ABC);
    issue_wait(RDNX, 8'h0, n);
    e = rd_exp.pop_front();
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL read_ack_latency got %0d want 5", n); end
    vectors++; if (n_valid - base !== 1) begin miscompares++; $display("FAIL read_valid got %0d want 1", n_valid - base); end
    vectors++; if (bus.o_gpio[12:0] !== e) begin miscompares++; $display("FAIL read_data got %h want %h", bus.o_gpio[12:0], e); end
    bus.i_data = 13'h1555;
  endtask

  task automatic test_back_to_back();
    int k, base;
    logic [7:0] e, g;
    base = n_load;
    issue(STRT, 8'h0);
    repeat (3) tick();
    exp_q.push_back(8'h5A);
    issue(LIMG, 8'h5A);
    repeat (4) tick();
    vectors++; if ({bus.o_gpio[27:25], n_load - base} !== {3'd2, 32'd0}) begin miscompares++; $display("FAIL b2b_held got state=%0d loads=%0d want 2/0", bus.o_gpio[27:25], n_load - base); end
    bus.i_eop = 1'b1;
    tick();
    bus.i_eop = 1'b0;
    k = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (k < 0 && n_load > base) k = i;
    end
    vectors++; if (k !== 3) begin miscompares++; $display("FAIL b2b_delay got %0d want 3", k); end
    vectors++; if (n_load - base !== 1) begin miscompares++; $display("FAIL b2b_once got %0d want 1", n_load - base); end
    vectors++; if ({bus.o_gpio[31], bus.o_gpio[30], bus.o_gpio[29]} !== {1'b0, 1'b1, strb}) begin miscompares++; $display("FAIL b2b_status got %b want %b", bus.o_gpio[31:29], {2'b01, strb}); end
    e = exp_q.pop_front();
    g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
    vectors++; if (g !== e) begin miscompares++; $display("FAIL b2b_data got %h want %h", g, e); end
  endtask

  task automatic test_async_reset();
    int base;
    issue(STRT, 8'h0);
    tick(); tick();
    base = n_load + n_sop + n_valid + n_srst;
    #2 i_reset = 1'b1;
    #1;
    vectors++; if (bus.o_gpio !== 32'h0) begin miscompares++; $display("FAIL async_gpio got %h want 0", bus.o_gpio); end
    vectors++; if ({bus.o_imglen, bus.o_ki} !== 5'b11111) begin miscompares++; $display("FAIL async_imglen_ki got %h/%b want f/1", bus.o_imglen, bus.o_ki); end
    strb = 1'b0;
    bus.i_gpio = '0;
    repeat (3) tick();
    i_reset = 1'b0;
    repeat (3) tick();
    vectors++; if (n_load + n_sop + n_valid + n_srst - base !== 0) begin miscompares++; $display("FAIL async_no_pulses got %0d want 0", n_load + n_sop + n_valid + n_srst - base); end
    vectors++; if (bus.o_gpio !== 32'h0) begin miscompares++; $display("FAIL async_idle got %h want 0", bus.o_gpio); end
    vectors++; if (wide !== 0) begin miscompares++; $display("FAIL pulse_width got %0d wide pulses want 0", wide); end
  endtask

  initial begin
    test_reset();
    test_start_early();
    test_imglen();
    test_kernel();
    test_full_run();
    test_read();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
